// File: rtl/float_argmax_ctrl.sv
// Argmax sequencer: streams N floats through an external combinational comparator
// and reports the largest value with its (first) index once per frame.
module float_argmax_ctrl #(
  parameter int N     = 10,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [31:0]      cmp_a,
  output logic [31:0]      cmp_b,
  input  logic [2:0]       cmp_flag,
  output logic             busy,
  output logic [31:0]      out_max,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [31:0]      max_val_q, max_val_d;
  logic [IDX_W-1:0] max_idx_q, max_idx_d;
  logic             accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      max_val_q <= '0;
      max_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      max_val_q <= max_val_d;
      max_idx_q <= max_idx_d;
    end
  end

  assign accept = (state_q == RUN) && in_valid;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    max_val_d = max_val_q;
    max_idx_d = max_idx_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (accept) begin
          // Element 0 seeds the running max; only a strict "A>B" flag replaces it,
          // so ties and any malformed flag keep the earlier index.
          if (cnt_q == '0) begin
            max_val_d = in_data;
            max_idx_d = '0;
          end else if (cmp_flag == 3'b100) begin
            max_val_d = in_data;
            max_idx_d = cnt_q;
          end
          if (cnt_q == LAST_IDX) begin
            state_d = DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The result registers double as the outputs, so they keep the last answer in IDLE.
  assign in_ready  = (state_q == RUN);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign out_max   = max_val_q;
  assign out_idx   = max_idx_q;
  assign cmp_a     = in_data;
  assign cmp_b     = max_val_q;

endmodule

// File: tb/tb_float_argmax_ctrl.sv
// Scoreboard bench for float_argmax_ctrl: real-valued argmax reference model,
// behavioural float comparator, and an N=1 instance for the degenerate frame.
module tb_float_argmax_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, in_valid, in_ready, busy, out_valid, out_ready;
  logic [31:0] in_data, cmp_a, cmp_b, out_max;
  logic [2:0]  cmp_flag;
  logic [3:0]  out_idx;

  logic        s1_start, s1_in_valid, s1_in_ready, s1_busy, s1_out_valid, s1_out_ready;
  logic [31:0] s1_in_data, s1_cmp_a, s1_cmp_b, s1_out_max;
  logic [2:0]  s1_cmp_flag;
  logic [0:0]  s1_out_idx;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_max_q[$];
  logic [3:0]  exp_idx_q[$];

  logic [31:0] fa [10];
  logic [31:0] fn [10];
  logic [31:0] fr [10];

  always #5 clk = ~clk;

  float_argmax_ctrl #(.N(10), .IDX_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_flag(cmp_flag), .busy(busy),
    .out_max(out_max), .out_idx(out_idx), .out_valid(out_valid), .out_ready(out_ready)
  );

  float_argmax_ctrl #(.N(1), .IDX_W(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(s1_start), .in_data(s1_in_data), .in_valid(s1_in_valid),
    .in_ready(s1_in_ready), .cmp_a(s1_cmp_a), .cmp_b(s1_cmp_b), .cmp_flag(s1_cmp_flag),
    .busy(s1_busy), .out_max(s1_out_max), .out_idx(s1_out_idx), .out_valid(s1_out_valid),
    .out_ready(s1_out_ready)
  );

  function automatic real f2r(input logic [31:0] b);
    real m;
    int  e;
    e = int'(b[30:23]);
    if (e == 0) m = (real'(b[22:0]) / 8388608.0) * (2.0 ** (-126));
    else        m = (1.0 + real'(b[22:0]) / 8388608.0) * (2.0 ** (e - 127));
    return b[31] ? -m : m;
  endfunction

  function automatic logic [2:0] fcmp(input logic [31:0] a, input logic [31:0] b);
    real ra, rb;
    ra = f2r(a);
    rb = f2r(b);
    if (ra > rb)       return 3'b100;
    else if (ra == rb) return 3'b010;
    else               return 3'b001;
  endfunction

  assign cmp_flag    = fcmp(cmp_a, cmp_b);
  assign s1_cmp_flag = fcmp(s1_cmp_a, s1_cmp_b);

  // Reference: largest real value, then the first position holding it.
  task automatic ref_argmax(input logic [31:0] v [10], output logic [31:0] em, output logic [3:0] ei);
    real best;
    best = f2r(v[0]);
    for (int i = 1; i < 10; i++) if (f2r(v[i]) > best) best = f2r(v[i]);
    ei = 4'd0;
    for (int i = 9; i >= 0; i--) if (f2r(v[i]) == best) ei = 4'(i);
    em = v[ei];
  endtask

  function automatic logic [31:0] rand_f();
    logic [7:0] e;
    if ($urandom_range(9) == 0) return 32'h0;
    e = 8'($urandom_range(134, 120));
    return {1'($urandom), e, 23'($urandom)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic send_frame(input logic [31:0] v [10], input int bubble_pct);
    logic [31:0] em;
    logic [3:0]  ei;
    ref_argmax(v, em, ei);
    exp_max_q.push_back(em);
    exp_idx_q.push_back(ei);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    for (int i = 0; i < 10; i++) begin
      while ($urandom_range(99) < bubble_pct) begin
        in_valid = 1'b0;
        in_data  = $urandom;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = v[i];
      chk("ready_noresult_at_accept", 32'({in_ready, out_valid}), 32'b10);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_data  = $urandom;
    chk("out_valid_after_last_accept", 32'(out_valid), 32'd1);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 30; k++) begin
      if (!busy) break;
      @(posedge clk); #1;
    end
    chk("return_to_idle", 32'({busy, out_valid}), 32'b00);
  endtask

  // Monitor: pops the scoreboard on every handshake and checks hold stability.
  logic        hold_prev = 1'b0;
  logic [31:0] prev_max;
  logic [3:0]  prev_idx;
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (in_ready && (out_valid || !busy)) begin
        errors++;
        $display("FAIL in_ready_outside_run: in_ready=%b busy=%b out_valid=%b", in_ready, busy, out_valid);
      end
      if (hold_prev) begin
        checks++;
        if (!out_valid || out_max !== prev_max || out_idx !== prev_idx) begin
          errors++;
          $display("FAIL result_hold: got v=%b %h/%0d, expected 1 %h/%0d", out_valid, out_max, out_idx, prev_max, prev_idx);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_max_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result: got %h/%0d, expected none", out_max, out_idx);
        end else begin
          logic [31:0] em;
          logic [3:0]  ei;
          em = exp_max_q.pop_front();
          ei = exp_idx_q.pop_front();
          if (out_max !== em || out_idx !== ei) begin
            errors++;
            $display("FAIL argmax_result: got %h/%0d, expected %h/%0d", out_max, out_idx, em, ei);
          end else begin
            $display("result max=%h idx=%0d", out_max, out_idx);
          end
        end
      end
      hold_prev = out_valid && !out_ready;
      prev_max  = out_max;
      prev_idx  = out_idx;
    end else begin
      hold_prev = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    fa = '{32'h3F800000, 32'h40600000, 32'h40000000, 32'h40E80000, 32'h40E80000,
           32'h3F000000, 32'hBF800000, 32'h40C00000, 32'h00000000, 32'h40800000};
    fn = '{32'hC0400000, 32'hBF000000, 32'hC0000000, 32'hC0800000, 32'hBFC00000,
           32'hC1000000, 32'hBF400000, 32'hC0A00000, 32'hBF800000, 32'hC0C00000};
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    s1_start = 1'b0; s1_in_valid = 1'b0; s1_in_data = '0; s1_out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {27'd0, in_ready, busy, out_valid, 2'b00}, 32'd0);
    chk("reset_out_max", out_max, 32'd0);
    chk("reset_out_idx", 32'(out_idx), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    send_frame(fa, 0);
    wait_idle();
    send_frame(fn, 0);
    wait_idle();
    send_frame(fa, 50);
    wait_idle();

    // Result held under back-pressure while start is pulsed in DONE.
    out_ready = 1'b0;
    send_frame(fn, 0);
    for (int k = 0; k < 5; k++) begin
      start = (k == 2);
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("held_valid", 32'({busy, out_valid}), 32'b11);
    out_ready = 1'b1;
    wait_idle();
    chk("retained_max_in_idle", out_max, 32'hBF000000);
    chk("retained_idx_in_idle", 32'(out_idx), 32'd1);
    send_frame(fa, 0);
    wait_idle();

    // Asynchronous reset mid-frame after four accepts.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = fa[i + 1];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_flags", 32'({in_ready, busy, out_valid}), 32'd0);
    chk("async_reset_max", out_max, 32'd0);
    chk("async_reset_idx", 32'(out_idx), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_frame(fn, 0);
    wait_idle();

    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < 10; i++) begin
        if (i > 0 && $urandom_range(3) == 0) fr[i] = fr[$urandom_range(i - 1)];
        else fr[i] = rand_f();
      end
      send_frame(fr, (f % 2 == 0) ? 50 : 0);
      wait_idle();
    end

    // N=1 instance: single element goes straight to DONE with index 0.
    s1_start = 1'b1;
    @(posedge clk); #1;
    s1_start = 1'b0;
    s1_in_valid = 1'b1;
    s1_in_data  = 32'h3F800000;
    chk("n1_not_valid_before_accept", 32'({s1_in_ready, s1_out_valid}), 32'b10);
    @(posedge clk); #1;
    s1_in_valid = 1'b0;
    s1_in_data  = 32'hDEADBEEF;
    chk("n1_out_valid", 32'(s1_out_valid), 32'd1);
    chk("n1_out_max", s1_out_max, 32'h3F800000);
    chk("n1_out_idx", 32'(s1_out_idx), 32'd0);
    s1_out_ready = 1'b1;
    @(posedge clk); #1;
    s1_out_ready = 1'b0;
    chk("n1_back_to_idle", 32'({s1_busy, s1_out_valid}), 32'd0);

    chk("scoreboard_drained", 32'(exp_max_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
